// File: rtl/sls_8bit_dncnt_timer.sv
// ============================================================================
// Module      : sls_8bit_dncnt_timer
// Description : Loadable down-counting timer with one-shot / auto-reload modes
//               and start, stop, retrigger and pause control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sls_8bit_dncnt_timer #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] D,
  input  logic             LD_EN,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Cnt_EN,
  input  logic             Auto_RL,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             tc_q, tc_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;

    if (LD_EN) begin
      rld_d   = D;
      cnt_d   = D;
      state_d = ST_IDLE;
    end else if (Stop) begin
      state_d = ST_IDLE;
    end else if (Start) begin
      cnt_d = rld_q;
      if (rld_q != C_ZERO) begin
        state_d = ST_RUN;
      end else begin
        // A zero reload terminates immediately; auto-reload keeps running
        tc_d    = 1'b1;
        state_d = Auto_RL ? ST_RUN : ST_DONE;
      end
    end else if ((state_q == ST_RUN) && Cnt_EN) begin
      if (cnt_q == C_ZERO) begin
        // Only reachable in auto-reload: the reload cycle closes the period
        cnt_d = rld_q;
        tc_d  = (rld_q == C_ZERO);
      end else if (cnt_q == C_ONE) begin
        cnt_d   = C_ZERO;
        tc_d    = 1'b1;
        state_d = Auto_RL ? ST_RUN : ST_DONE;
      end else begin
        cnt_d = cnt_q - C_ONE;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= C_ZERO;
      rld_q   <= C_ZERO;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
    end
  end

  assign Q    = cnt_q;
  assign TC   = tc_q;
  assign Busy = (state_q == ST_RUN);
  assign Done = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: doc/sls_8bit_dncnt_timer.md
Name: sls_8bit_dncnt_timer

Overview:
Loadable down-counting timer, the counterpart to the team's loadable 8-bit up-counter. It counts down from a programmed reload value to zero and flags terminal count. It supports one-shot and auto-reload (periodic) modes, and start, stop and retrigger control. It is used as the delay/timeout generator beside the lab memory datapath.

Parameters:
WIDTH, 8, width of the count and reload registers.

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-high reset.
D  input  WIDTH  reload value.
LD_EN  input  1  load D into the reload register and into Q.
Start  input  1  start or retrigger the countdown from the reload value.
Stop  input  1  abort the countdown and return to IDLE.
Cnt_EN  input  1  count enable; when low in RUN, Q holds (pause).
Auto_RL  input  1  1 = periodic auto-reload, 0 = one-shot.
Q  output  WIDTH  current count.
TC  output  1  terminal count, registered, one cycle per event.
Busy  output  1  high while in RUN.
Done  output  1  high while in DONE.

Behaviour:
- Registers: Q, reload register R (WIDTH bits), state (IDLE, RUN, DONE), TC.
- Reset asserted (async, at any time including mid-count): Q=0, R=0, state=IDLE, TC=0, so Busy=0 and Done=0. Held while Reset=1.
- Busy=(state==RUN) and Done=(state==DONE), decoded from the state register.
- TC defaults to 0 every cycle unless set by a rule below.
- Per-edge priority: LD_EN > Stop > Start > counting.
- LD_EN=1, any state: R<=D, Q<=D, state<=IDLE.
- Stop=1, any state: state<=IDLE, Q holds.
- Start=1 in IDLE, RUN (retrigger) or DONE: Q<=R.
  - R!=0: state<=RUN.
  - R==0 and Auto_RL=0: state<=DONE, TC<=1.
  - R==0 and Auto_RL=1: state<=RUN, TC<=1.
- IDLE with no command: Q holds.
- DONE with no command: Q holds at 0.
- RUN with Cnt_EN=0: Q holds; state and TC unchanged except that TC clears.
- RUN with Cnt_EN=1 and Q>1: Q<=Q-1.
- RUN with Cnt_EN=1 and Q==1: Q<=0, TC<=1.
  - Auto_RL=0: state<=DONE.
  - Auto_RL=1: stay in RUN.
- RUN with Cnt_EN=1 and Q==0 (reachable only in auto-reload): Q<=R, and TC<=1 if R==0.
- Timing and period:
  - TC rises in the same cycle Q becomes 0.
  - One-shot duration: R enabled cycles from Start to TC.
  - Auto-reload period: R+1 enabled cycles between TC pulses.
  - R==0 with Auto_RL=1: TC is high on every enabled cycle.
- Auto_RL is sampled at the cycle Q reaches 0. Changing it mid-count is legal.
- Arithmetic is unsigned modulo 2^WIDTH. Q never decrements below 0, because the Q==0 and Q==1 cases are handled explicitly (no underflow wrap).
- Cycle latency: 0 extra. Every output is registered or decoded from a register, and all effects are visible after the capturing edge.

Test Plan:
- Reset mid-count: load 8'h10, Start, run 5 cycles, pulse Reset between edges -> Q, TC, Busy, Done go to 0 immediately without waiting for a clock edge. After release, Start -> Q=0, Done=1, TC=1 (R was cleared).
- One-shot: LD_EN with D=8'd5, Start, Auto_RL=0, Cnt_EN=1 -> Q steps 5,4,3,2,1,0. TC=1 only in the cycle Q=0. Done=1 and Busy=0 from then on, and Q holds 0.
- Auto-reload: D=8'd3, Auto_RL=1 -> Q cycles 3,2,1,0,3,2,1,0… and TC pulses every 4 cycles. Busy stays high.
- Pause, retrigger, stop: D=8'd10. Cnt_EN=0 for 3 cycles at Q=7 -> Q holds 7. Start at Q=4 -> Q=10 next edge. Stop -> state IDLE, Q frozen, Busy=0.
- Priority: LD_EN, Stop and Start asserted together with D=8'hAA -> Q=8'hAA and state IDLE. Start+Stop together -> IDLE.
- Zero and max: D=0 with Start -> Done plus a single TC pulse. D=8'hFF one-shot -> TC after exactly 255 enabled cycles, with no underflow to 8'hFF afterward.
